// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose
//   Memory-side responder to the decoder's memrd/memw controls. Each load or
//   store becomes exactly one request/grant/rvalid data-bus transaction. The
//   unit stalls the core while the access is in flight, forms byte enables and
//   lane-replicated store data, and aligns plus sign/zero-extends load data for
//   the writeback mux.
//
// Parameters
//   TIMEOUT   cycles allowed in REQ+WAIT before a bus error is raised (>= 2)
//
// Configuration macro
//   MISALIGN_TRAP_EN  defined: a halfword with a[0]=1 or a word with a[1:0]!=0
//                     goes straight to ERR with no bus access.
//                     undefined: low address bits that break alignment are
//                     ignored and the access proceeds normally.
//
// Ports
//   clk_i      in   1   clock, rising edge
//   rst_i      in   1   asynchronous, active-high reset
//   memrd_i    in   1   load request, held stable while stall_o=1
//   memw_i     in   1   store request, held stable while stall_o=1
//   funct3_i   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//   addr_i     in   32  effective byte address
//   wdata_i    in   32  store data
//   stall_o    out  1   freeze pipeline
//   done_o     out  1   one-cycle pulse: access finished, rdata_o/err_o valid
//   err_o      out  1   one-cycle pulse with done_o on any fault
//   rdata_o    out  32  aligned, extended load data; 0 for stores/errors
//   req_o      out  1   bus request
//   we_o       out  1   bus write enable
//   be_o       out  4   bus byte enables
//   baddr_o    out  32  word-aligned bus address
//   bwdata_o   out  32  lane-replicated store data
//   gnt_i      in   1   bus accepted request
//   rvalid_i   in   1   bus response (read data or write ack)
//   brdata_i   in   32  bus read data
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        memrd_i,
   input  logic        memw_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        req_o,
   output logic        we_o,
   output logic [3:0]  be_o,
   output logic [31:0] baddr_o,
   output logic [31:0] bwdata_o,
   input  logic        gnt_i,
   input  logic        rvalid_i,
   input  logic [31:0] brdata_i
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t         state_q, state_d;
   logic           req_q, req_d;
   logic           we_q, we_d;
   logic [3:0]     be_q, be_d;
   logic [31:0]    baddr_q, baddr_d;
   logic [31:0]    bwdata_q, bwdata_d;
   logic [1:0]     off_q, off_d;      // effective byte lane of the access
   logic [2:0]     f3_q, f3_d;
   logic           load_q, load_d;
   logic [31:0]    rdata_q, rdata_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   // ---------------------------------------------------------------------------
   // Request decode (IDLE-side view of the incoming access)
   // ---------------------------------------------------------------------------
   logic        req_any;
   logic [1:0]  size;
   logic [1:0]  eff_off;
   logic [3:0]  be_calc;
   logic [31:0] bwdata_calc;
   logic        f3_legal;
   logic        misalign;
   logic        fault;

   always_comb begin
      req_any = memrd_i | memw_i;
      size    = funct3_i[1:0];

      // Halfwords always use an even lane pair and words lane 0, so the lane
      // offset is the address with the alignment-breaking bits dropped.
      unique case (size)
         2'b00:   eff_off = addr_i[1:0];
         2'b01:   eff_off = {addr_i[1], 1'b0};
         default: eff_off = 2'b00;
      endcase

      unique case (size)
         2'b00:   be_calc = 4'b0001 << eff_off;
         2'b01:   be_calc = 4'b0011 << eff_off;
         default: be_calc = 4'b1111;
      endcase

      bwdata_calc = 32'h0;
      if (memw_i) begin
         unique case (size)
            2'b00:   bwdata_calc = {4{wdata_i[7:0]}};
            2'b01:   bwdata_calc = {2{wdata_i[15:0]}};
            default: bwdata_calc = wdata_i;
         endcase
      end

      // Unsigned variants exist only for loads.
      unique case (funct3_i)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = memrd_i;
         default:                f3_legal = 1'b0;
      endcase

`ifdef MISALIGN_TRAP_EN
      misalign = ((size == 2'b01) && addr_i[0]) ||
                 ((size == 2'b10) && (addr_i[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif

      fault = (memrd_i & memw_i) | ~f3_legal | misalign;
   end

   // ---------------------------------------------------------------------------
   // Load alignment and extension from the live bus data
   // ---------------------------------------------------------------------------
   logic [31:0] load_shift;
   logic [31:0] load_ext;

   always_comb begin
      load_shift = brdata_i >> {off_q, 3'b000};
      unique case (f3_q)
         3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
         3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
         3'b100:  load_ext = {24'h0, load_shift[7:0]};
         3'b101:  load_ext = {16'h0, load_shift[15:0]};
         default: load_ext = load_shift;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: every flop is updated with <= so all of them see the same
   // pre-edge values; the capture registers carry no data worth keeping
   // across reset but are cleared anyway so every output reads 0 in reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         be_q     <= 4'h0;
         baddr_q  <= 32'h0;
         bwdata_q <= 32'h0;
         off_q    <= 2'b00;
         f3_q     <= 3'b000;
         load_q   <= 1'b0;
         rdata_q  <= 32'h0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         be_q     <= be_d;
         baddr_q  <= baddr_d;
         bwdata_q <= bwdata_d;
         off_q    <= off_d;
         f3_q     <= f3_d;
         load_q   <= load_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath
   // ---------------------------------------------------------------------------
   logic [CW-1:0] cnt_inc;
   logic          timeout_hit;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      be_d     = be_q;
      baddr_d  = baddr_q;
      bwdata_d = bwdata_q;
      off_d    = off_q;
      f3_d     = f3_q;
      load_d   = load_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;

      cnt_inc     = cnt_q + CW'(1);
      timeout_hit = (cnt_inc == CW'(TIMEOUT));

      unique case (state_q)
         S_IDLE: begin
            if (req_any) begin
               cnt_d   = '0;
               f3_d    = funct3_i;
               load_d  = memrd_i;
               off_d   = eff_off;
               rdata_d = 32'h0;
               if (fault) begin
                  state_d = S_ERR;
               end else begin
                  state_d  = S_REQ;
                  req_d    = 1'b1;
                  we_d     = memw_i;
                  be_d     = be_calc;
                  baddr_d  = {addr_i[31:2], 2'b00};
                  bwdata_d = bwdata_calc;
               end
            end
         end

         S_REQ, S_WAIT: begin
            cnt_d = cnt_inc;
            // Bus progress in the same cycle wins over the timeout.
            if (state_q == S_REQ && gnt_i) begin
               req_d    = 1'b0;
               we_d     = 1'b0;
               be_d     = 4'h0;
               baddr_d  = 32'h0;
               bwdata_d = 32'h0;
               if (rvalid_i) begin
                  rdata_d = load_q ? load_ext : 32'h0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end else if (state_q == S_WAIT && rvalid_i) begin
               rdata_d = load_q ? load_ext : 32'h0;
               state_d = S_DONE;
            end else if (timeout_hit) begin
               req_d    = 1'b0;
               we_d     = 1'b0;
               be_d     = 4'h0;
               baddr_d  = 32'h0;
               bwdata_d = 32'h0;
               state_d  = S_ERR;
            end
         end

         // The core advances during DONE/ERR, so requests are not re-sampled.
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      stall_o = 1'b0;
      done_o  = 1'b0;
      err_o   = 1'b0;
      rdata_o = 32'h0;

      unique case (state_q)
         // Gated by reset so the stall request cannot leak out during reset.
         S_IDLE:        stall_o = req_any & ~rst_i;
         S_REQ, S_WAIT: stall_o = 1'b1;
         S_DONE: begin
            done_o  = 1'b1;
            rdata_o = rdata_q;
         end
         S_ERR: begin
            done_o = 1'b1;
            err_o  = 1'b1;
         end
         default: stall_o = 1'b0;
      endcase
   end

   assign req_o    = req_q;
   assign we_o     = we_q;
   assign be_o     = be_q;
   assign baddr_o  = baddr_q;
   assign bwdata_o = bwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. Each access pushes its expected
// completion (err, rdata) into a queue; an independent monitor pops and
// compares every time done_o pulses. Bus-side fields, stall length and
// completion latency are compared inline by the access task.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        memrd_i, memw_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, done_o, err_o;
   logic [31:0] rdata_o;
   logic        req_o, we_o;
   logic [3:0]  be_o;
   logic [31:0] baddr_o, bwdata_o;
   logic        gnt_i, rvalid_i;
   logic [31:0] brdata_i;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   resp_t sb_q[$];

   always #5 clk_i = ~clk_i;

   load_store_unit #(.TIMEOUT(16)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .memrd_i  (memrd_i),
      .memw_i   (memw_i),
      .funct3_i (funct3_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .err_o    (err_o),
      .rdata_o  (rdata_o),
      .req_o    (req_o),
      .we_o     (we_o),
      .be_o     (be_o),
      .baddr_o  (baddr_o),
      .bwdata_o (bwdata_o),
      .gnt_i    (gnt_i),
      .rvalid_i (rvalid_i),
      .brdata_i (brdata_i)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Completion monitor
   always @(negedge clk_i) begin
      if (!rst_i && done_o) begin
         if (sb_q.size() == 0) begin
            check("unexpected done_o", 64'd1, 64'd0);
         end else begin
            resp_t e;
            e = sb_q.pop_front();
            check("resp err_o", {63'd0, err_o}, {63'd0, e.err});
            check("resp rdata_o", {32'd0, rdata_o}, {32'd0, e.rdata});
         end
      end
   end

   // One access with an in-task bus responder. Called and returns just after
   // a rising edge with the unit idle.
   task automatic run_access(
      input string       name,
      input logic        rd,
      input logic        wr,
      input logic [2:0]  f3,
      input logic [31:0] a,
      input logic [31:0] wd,
      input int          gnt_wait,     // REQ cycles before gnt_i is given
      input logic        same_cyc_rv,  // rvalid_i together with gnt_i
      input logic [31:0] bdata,
      input logic        exp_bus,
      input logic        exp_we,
      input logic [3:0]  exp_be,
      input logic [31:0] exp_baddr,
      input logic [31:0] exp_bwdata,
      input logic [31:0] exp_rdata,
      input logic        exp_err,
      input int          exp_lat,
      output int         req_cnt
   );
      int   cyc = 0;
      int   stall_cnt = 0;
      logic seen_bus = 1'b0;
      logic rv_next = 1'b0;
      logic done_seen = 1'b0;
      resp_t e;
      e.err   = exp_err;
      e.rdata = exp_rdata;
      sb_q.push_back(e);
      req_cnt  = 0;
      memrd_i  = rd;
      memw_i   = wr;
      funct3_i = f3;
      addr_i   = a;
      wdata_i  = wd;
      brdata_i = bdata;
      while (cyc < 60) begin
         #1;
         if (done_o) begin
            done_seen = 1'b1;
            break;
         end
         if (stall_o) stall_cnt++;
         gnt_i    = 1'b0;
         rvalid_i = 1'b0;
         if (req_o) begin
            if (!seen_bus) begin
               seen_bus = 1'b1;
               check({name, " we_o"}, {63'd0, we_o}, {63'd0, exp_we});
               check({name, " be_o"}, {60'd0, be_o}, {60'd0, exp_be});
               check({name, " baddr_o"}, {32'd0, baddr_o}, {32'd0, exp_baddr});
               check({name, " bwdata_o"}, {32'd0, bwdata_o}, {32'd0, exp_bwdata});
            end
            if (req_cnt == gnt_wait) begin
               gnt_i    = 1'b1;
               rvalid_i = same_cyc_rv;
               rv_next  = ~same_cyc_rv;
            end
            req_cnt++;
         end else if (rv_next) begin
            rvalid_i = 1'b1;
            rv_next  = 1'b0;
         end
         @(posedge clk_i);
         cyc++;
      end
      memrd_i  = 1'b0;
      memw_i   = 1'b0;
      gnt_i    = 1'b0;
      rvalid_i = 1'b0;
      check({name, " completed"}, {63'd0, done_seen}, 64'd1);
      check({name, " latency"}, 64'(cyc), 64'(exp_lat));
      check({name, " stall cycles"}, 64'(stall_cnt), 64'(exp_lat));
      check({name, " bus used"}, {63'd0, seen_bus}, {63'd0, exp_bus});
      @(posedge clk_i);
      #1;
      check({name, " done pulse width"}, {63'd0, done_o}, 64'd0);
   endtask

   initial begin
      int rq;
      rst_i    = 1'b1;
      memrd_i  = 1'b0;
      memw_i   = 1'b0;
      funct3_i = 3'b000;
      addr_i   = 32'h0;
      wdata_i  = 32'h0;
      gnt_i    = 1'b0;
      rvalid_i = 1'b0;
      brdata_i = 32'h0;

      repeat (2) @(posedge clk_i);
      #1;
      check("reset outputs",
            {25'd0, stall_o, done_o, err_o, req_o, we_o, be_o, rdata_o | baddr_o | bwdata_o},
            64'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // LW, grant on first REQ cycle, rvalid one cycle later
      run_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
                 1, 0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF, 0, 3, rq);
      check("lw req cycles", 64'(rq), 64'd1);
      // LB / LBU from the top lane
      run_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF,
                 1, 0, 4'b1000, 32'h100, 32'h0, 32'hFFFFFF80, 0, 3, rq);
      run_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FFFFFF,
                 1, 0, 4'b1000, 32'h100, 32'h0, 32'h00000080, 0, 3, rq);
      // LB positive value, lane 1
      run_access("lb_pos", 1, 0, 3'b000, 32'h101, 32'h0, 0, 0, 32'h00007F00,
                 1, 0, 4'b0010, 32'h100, 32'h0, 32'h0000007F, 0, 3, rq);
      // LH / LHU upper half
      run_access("lh", 1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80011234,
                 1, 0, 4'b1100, 32'h100, 32'h0, 32'hFFFF8001, 0, 3, rq);
      run_access("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80011234,
                 1, 0, 4'b1100, 32'h100, 32'h0, 32'h00008001, 0, 3, rq);
      // SH upper half, SB lane 1
      run_access("sh", 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'hFFFFFFFF,
                 1, 1, 4'b1100, 32'h200, 32'hABCDABCD, 32'h0, 0, 3, rq);
      run_access("sb", 0, 1, 3'b000, 32'h001, 32'h000000A5, 0, 0, 32'h0,
                 1, 1, 4'b0010, 32'h0, 32'hA5A5A5A5, 32'h0, 0, 3, rq);
      // Grant and rvalid in the same cycle
      run_access("lw_fast", 1, 0, 3'b010, 32'h104, 32'h0, 0, 1, 32'h11223344,
                 1, 0, 4'b1111, 32'h104, 32'h0, 32'h11223344, 0, 2, rq);
      // Grant held off three cycles
      run_access("lw_slow", 1, 0, 3'b010, 32'h500, 32'h0, 3, 0, 32'h0BADF00D,
                 1, 0, 4'b1111, 32'h500, 32'h0, 32'h0BADF00D, 0, 6, rq);
      check("lw_slow req cycles", 64'(rq), 64'd4);

      // Bus timeout: grant never comes within the budget
      run_access("timeout", 1, 0, 3'b010, 32'h400, 32'h0, 20, 0, 32'h0,
                 1, 0, 4'b1111, 32'h400, 32'h0, 32'h0, 1, 17, rq);
      check("timeout req cycles", 64'(rq), 64'd16);
      // A stray late response in IDLE is ignored
      for (int i = 0; i < 2; i++) begin
         gnt_i    = 1'b1;
         rvalid_i = 1'b1;
         @(posedge clk_i);
         #1;
         check("stray rvalid ignored", {62'd0, done_o, req_o}, 64'd0);
      end
      gnt_i    = 1'b0;
      rvalid_i = 1'b0;

      // Faults decoded in IDLE never touch the bus
      run_access("rd_and_wr", 1, 1, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0,
                 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 1, rq);
      run_access("bad_f3_load", 1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0,
                 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 1, rq);
      run_access("bu_store", 0, 1, 3'b100, 32'h100, 32'h55, 0, 0, 32'h0,
                 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 1, rq);

      // Misaligned word store
`ifdef MISALIGN_TRAP_EN
      run_access("sw_mis", 0, 1, 3'b010, 32'h301, 32'hCAFEF00D, 0, 0, 32'h0,
                 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1, 1, rq);
`else
      run_access("sw_mis", 0, 1, 3'b010, 32'h301, 32'hCAFEF00D, 0, 0, 32'h0,
                 1, 1, 4'b1111, 32'h300, 32'hCAFEF00D, 32'h0, 0, 3, rq);
`endif

      // Reset while waiting for rvalid
      memrd_i  = 1'b1;
      funct3_i = 3'b010;
      addr_i   = 32'h600;
      @(posedge clk_i);
      #1;
      check("rst_test in REQ", {62'd0, req_o, stall_o}, 64'd3);
      gnt_i = 1'b1;
      @(posedge clk_i);
      #1;
      gnt_i = 1'b0;
      check("rst_test in WAIT", {62'd0, req_o, stall_o}, 64'd1);
      rst_i    = 1'b1;
      rvalid_i = 1'b1;
      brdata_i = 32'hFFFFFFFF;
      #1;
      check("rst mid-access outputs",
            {25'd0, stall_o, done_o, err_o, req_o, we_o, be_o, rdata_o | baddr_o | bwdata_o},
            64'd0);
      memrd_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("after reset rvalid ignored", {62'd0, done_o, req_o}, 64'd0);
      rvalid_i = 1'b0;

      run_access("lw_after_rst", 1, 0, 3'b010, 32'h700, 32'h0, 0, 0, 32'h13579BDF,
                 1, 0, 4'b1111, 32'h700, 32'h0, 32'h13579BDF, 0, 3, rq);

      repeat (3) @(posedge clk_i);
      check("scoreboard drained", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
